// File: rtl/ucsbece154b_mem_arbiter.sv
// Round-robin arbiter that shares one single-ported memory between the fetch and data ports.
// It keeps one transaction in flight and aborts it after TIMEOUT wait cycles.
module ucsbece154b_mem_arbiter #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_rdata_o,
  output logic        if_ready_o,
  input  logic        d_req_i,
  input  logic        d_we_i,
  input  logic [31:0] d_addr_i,
  input  logic [31:0] d_wdata_i,
  output logic [31:0] d_rdata_o,
  output logic        d_ready_o,
  output logic        err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ready_i,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  localparam logic [7:0] TIMEOUT_CNT = TIMEOUT[7:0];
  localparam logic       LG_I = 1'b0;
  localparam logic       LG_D = 1'b1;

  // Memory handshake: one transaction retires in each cycle where mem_req_o
  // and mem_ready_i are both high; mem_* stays constant while mem_req_o is high.
  state_t      state, state_n;
  logic [7:0]  wait_cnt, wait_n;
  logic        last_grant, last_n;
  logic        mem_req_n, mem_we_n;
  logic [31:0] mem_addr_n, mem_wdata_n;
  logic [31:0] if_rdata_n, d_rdata_n;
  logic        if_ready_n, d_ready_n, err_n;
  logic        if_elig, d_elig, pick_d;

  assign dbg_state = state;

  // A requester whose ready pulse is showing is still being retired, so skip it.
  assign if_elig = if_req_i & ~if_ready_o;
  assign d_elig  = d_req_i & ~d_ready_o;
  assign pick_d  = d_elig & (~if_elig | (last_grant == LG_I));

  always_comb begin
    state_n     = state;
    wait_n      = wait_cnt;
    last_n      = last_grant;
    mem_req_n   = mem_req_o;
    mem_we_n    = mem_we_o;
    mem_addr_n  = mem_addr_o;
    mem_wdata_n = mem_wdata_o;
    if_rdata_n  = if_rdata_o;
    d_rdata_n   = d_rdata_o;
    if_ready_n  = 1'b0;
    d_ready_n   = 1'b0;
    err_n       = 1'b0;
    case (state)
      IDLE: begin
        if (if_elig | d_elig) begin
          wait_n    = 8'd0;
          mem_req_n = 1'b1;
          if (pick_d) begin
            state_n     = BUSY_D;
            mem_we_n    = d_we_i;
            mem_addr_n  = d_addr_i;
            mem_wdata_n = d_wdata_i;
          end else begin
            state_n     = BUSY_I;
            mem_we_n    = 1'b0;
            mem_addr_n  = if_addr_i;
            mem_wdata_n = 32'd0;
          end
        end
      end
      BUSY_I, BUSY_D: begin
        if (mem_ready_i || (wait_cnt == TIMEOUT_CNT)) begin
          // Completion beats timeout when both land in the same cycle.
          state_n   = IDLE;
          mem_req_n = 1'b0;
          err_n     = ~mem_ready_i;
          if (state == BUSY_I) begin
            if_ready_n = 1'b1;
            if_rdata_n = mem_ready_i ? mem_rdata_i : 32'd0;
            last_n     = LG_I;
          end else begin
            d_ready_n = 1'b1;
            d_rdata_n = (mem_ready_i && !mem_we_o) ? mem_rdata_i : 32'd0;
            last_n    = LG_D;
          end
        end else begin
          wait_n = wait_cnt + 8'd1;
        end
      end
      default: begin
        state_n   = IDLE;
        mem_req_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      wait_cnt    <= 8'd0;
      last_grant  <= LG_I;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= 32'd0;
      mem_wdata_o <= 32'd0;
      if_rdata_o  <= 32'd0;
      d_rdata_o   <= 32'd0;
      if_ready_o  <= 1'b0;
      d_ready_o   <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      state       <= state_n;
      wait_cnt    <= wait_n;
      last_grant  <= last_n;
      mem_req_o   <= mem_req_n;
      mem_we_o    <= mem_we_n;
      mem_addr_o  <= mem_addr_n;
      mem_wdata_o <= mem_wdata_n;
      if_rdata_o  <= if_rdata_n;
      d_rdata_o   <= d_rdata_n;
      if_ready_o  <= if_ready_n;
      d_ready_o   <= d_ready_n;
      err_o       <= err_n;
    end
  end

endmodule

// File: tb/tb_ucsbece154b_mem_arbiter.sv
// Directed bench for ucsbece154b_mem_arbiter: fetch, store with waits, round-robin,
// timeout and its boundary, and asynchronous reset in the middle of a transaction.
module tb_ucsbece154b_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req_i, d_req_i, d_we_i, mem_ready_i;
  logic [31:0] if_addr_i, d_addr_i, d_wdata_i, mem_rdata_i;
  logic [31:0] if_rdata_o, d_rdata_o, mem_addr_o, mem_wdata_o;
  logic        if_ready_o, d_ready_o, err_o, mem_req_o, mem_we_o;
  logic [1:0]  dbg_state;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  ucsbece154b_mem_arbiter #(.TIMEOUT(15)) dut (
    .clk(clk), .reset(reset),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o), .if_ready_o(if_ready_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
    .d_rdata_o(d_rdata_o), .d_ready_o(d_ready_o), .err_o(err_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ready_i(mem_ready_i),
    .dbg_state(dbg_state)
  );

  // Clock/reset block
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_req_i = 1'b0; if_addr_i = 32'd0;
    d_req_i = 1'b0; d_we_i = 1'b0; d_addr_i = 32'd0; d_wdata_i = 32'd0;
    mem_ready_i = 1'b0; mem_rdata_i = 32'd0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    logic [31:0] got;
    idle_inputs();
    reset = 1'b1;
    #1;
    check("rst_mem_req", mem_req_o, 0);
    check("rst_if_ready", if_ready_o, 0);
    check("rst_d_ready", d_ready_o, 0);
    check("rst_err", err_o, 0);
    check("rst_mem_addr", mem_addr_o, 0);
    check("rst_state", dbg_state, 0);
    tick();
    reset = 1'b0;

    // Lone fetch, zero-wait memory
    if_req_i = 1'b1; if_addr_i = 32'h100;
    tick();
    check("f_mem_req", mem_req_o, 1);
    check("f_mem_addr", mem_addr_o, 32'h100);
    check("f_mem_we", mem_we_o, 0);
    check("f_mem_wdata", mem_wdata_o, 0);
    mem_ready_i = 1'b1; mem_rdata_i = 32'h00500093;
    tick();
    check("f_if_ready", if_ready_o, 1);
    check("f_if_rdata", if_rdata_o, 32'h00500093);
    check("f_err", err_o, 0);
    check("f_mem_req_drop", mem_req_o, 0);
    if_req_i = 1'b0; mem_ready_i = 1'b0;
    tick();
    check("f_if_ready_once", if_ready_o, 0);

    // Store with three wait cycles; read data on the bus must not leak through
    d_req_i = 1'b1; d_we_i = 1'b1; d_addr_i = 32'h2000; d_wdata_i = 32'hDEADBEEF;
    mem_rdata_i = 32'h5555AAAA;
    for (int k = 1; k <= 4; k++) begin
      tick();
      check($sformatf("st_req_%0d", k), mem_req_o, 1);
      check($sformatf("st_we_%0d", k), mem_we_o, 1);
      check($sformatf("st_addr_%0d", k), mem_addr_o, 32'h2000);
      check($sformatf("st_wdata_%0d", k), mem_wdata_o, 32'hDEADBEEF);
      check($sformatf("st_noready_%0d", k), d_ready_o, 0);
    end
    mem_ready_i = 1'b1;
    tick();
    check("st_d_ready", d_ready_o, 1);
    check("st_d_rdata", d_rdata_o, 0);
    check("st_err", err_o, 0);
    check("st_mem_req_drop", mem_req_o, 0);
    idle_inputs();
    tick();

    // Both held after reset: D, I, D, I with one idle cycle between transactions
    pulse_reset();
    if_req_i = 1'b1; if_addr_i = 32'h400;
    d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h800;
    mem_ready_i = 1'b1; mem_rdata_i = 32'h1234;
    exp_q.push_back(32'd1); exp_q.push_back(32'd0);
    exp_q.push_back(32'd1); exp_q.push_back(32'd0);
    for (int k = 1; k <= 8; k++) begin
      tick();
      check($sformatf("rr_mem_req_%0d", k), mem_req_o, k % 2);
      check($sformatf("rr_not_both_%0d", k), if_ready_o & d_ready_o, 0);
      if (k % 2 == 1)
        check($sformatf("rr_addr_%0d", k), mem_addr_o, (k % 4 == 1) ? 32'h800 : 32'h400);
      if (if_ready_o || d_ready_o) begin
        got = {31'd0, d_ready_o};
        if (exp_q.size() == 0) check($sformatf("rr_extra_%0d", k), got, 32'hFFFFFFFF);
        else check($sformatf("rr_grant_%0d", k), got, exp_q.pop_front());
      end
    end
    check("rr_all_retired", exp_q.size(), 0);
    idle_inputs();
    tick();

    // Load with memory stuck low: abort after 16 request cycles
    d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h3000;
    for (int k = 1; k <= 16; k++) begin
      tick();
      check($sformatf("to_req_%0d", k), mem_req_o, 1);
      check($sformatf("to_noready_%0d", k), d_ready_o, 0);
    end
    tick();
    check("to_mem_req_drop", mem_req_o, 0);
    check("to_d_ready", d_ready_o, 1);
    check("to_err", err_o, 1);
    check("to_d_rdata", d_rdata_o, 0);
    d_req_i = 1'b0;
    tick();
    check("to_err_once", err_o, 0);

    // Ready exactly in the timeout cycle completes normally
    d_req_i = 1'b1; d_addr_i = 32'h3004;
    for (int k = 1; k <= 16; k++) tick();
    check("tb_req_16", mem_req_o, 1);
    mem_ready_i = 1'b1; mem_rdata_i = 32'hCAFEF00D;
    tick();
    check("tb_d_ready", d_ready_o, 1);
    check("tb_err", err_o, 0);
    check("tb_d_rdata", d_rdata_o, 32'hCAFEF00D);
    idle_inputs();
    tick();

    // Reset between edges while BUSY_D, with a fetch pending
    d_req_i = 1'b1; d_we_i = 1'b1; d_addr_i = 32'h5000; d_wdata_i = 32'h77;
    tick();
    check("ar_busy_d", dbg_state, 2);
    if_req_i = 1'b1; if_addr_i = 32'h600;
    #2;
    reset = 1'b1;
    #1;
    check("ar_mem_req_async", mem_req_o, 0);
    check("ar_state_async", dbg_state, 0);
    d_req_i = 1'b0;
    tick();
    check("ar_no_d_ready", d_ready_o, 0);
    reset = 1'b0;
    tick();
    check("ar_fetch_req", mem_req_o, 1);
    check("ar_fetch_addr", mem_addr_o, 32'h600);
    check("ar_fetch_we", mem_we_o, 0);
    check("ar_still_no_d_ready", d_ready_o, 0);
    // Dropping the request mid-transaction does not cancel it
    if_req_i = 1'b0;
    tick();
    check("ar_hold_req", mem_req_o, 1);
    mem_ready_i = 1'b1; mem_rdata_i = 32'h0BADF00D;
    tick();
    check("ar_if_ready", if_ready_o, 1);
    check("ar_if_rdata", if_rdata_o, 32'h0BADF00D);
    idle_inputs();
    tick();
    check("ar_quiet", mem_req_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
